// File: rtl/pwr_est_pkg.sv
// Shared types and sizing helpers for the toggle-activity power estimator.
package pwr_est_pkg;

   localparam int DROP_W = 8;

   typedef enum logic {
      ST_IDLE,
      ST_COUNT
   } cnt_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_MAC,
      R_HOLD
   } rpt_state_t;

   // Width of sum(weight*count) over n_sig nets; sized so the accumulator never overflows.
   function automatic int energy_width(input int cnt_w, input int weight_w, input int n_sig);
      return cnt_w + weight_w + $clog2(n_sig);
   endfunction

endpackage

// File: rtl/toggle_counter.sv
// One monitored net: previous-value flop, edge XOR and saturating toggle counter.
module toggle_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig,
   input  logic             cnt_en,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_sum
);

   logic             prev_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             toggle;
   logic [CNT_W:0]   cnt_inc;

   // cnt_sum already includes this cycle's toggle, so a window close can snapshot it directly.
   always_comb begin
      toggle  = sig ^ prev_reg;
      cnt_inc = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, toggle};
      cnt_sum = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_reg <= 1'b0;
         cnt_reg  <= '0;
      end else begin
         prev_reg <= sig;
         if (clr)
            cnt_reg <= '0;
         else if (cnt_en)
            cnt_reg <= cnt_sum;
      end
   end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Windowed per-net toggle counting with a sequential weighted-energy MAC and valid/ready report.
module toggle_activity_monitor
   import pwr_est_pkg::*;
#(
   parameter int N_SIG    = 2,
   parameter int CNT_W    = 16,
   parameter int WEIGHT_W = 8,
   parameter int WIN_LEN  = 64,
   parameter int E_W      = energy_width(CNT_W, WEIGHT_W, N_SIG)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [N_SIG-1:0]          sig_in,
   input  logic [N_SIG*WEIGHT_W-1:0] weights,
   output logic                      rpt_valid,
   input  logic                      rpt_ready,
   output logic [N_SIG*CNT_W-1:0]    rpt_toggles,
   output logic [E_W-1:0]            rpt_energy,
   output logic [DROP_W-1:0]         drop_cnt
);

   localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
   localparam int MI_W = $clog2(N_SIG + 1);
   localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);

   cnt_state_t             cnt_state_reg;
   logic [WC_W-1:0]        win_cnt_reg;
   rpt_state_t             rpt_state_reg;
   logic [MI_W-1:0]        mac_idx_reg;
   logic [E_W-1:0]         acc_reg;
   logic [N_SIG*CNT_W-1:0] shadow_reg;
   logic [N_SIG*CNT_W-1:0] cnt_sum;

   logic [WEIGHT_W-1:0]    weight_arr [N_SIG];
   logic [CNT_W-1:0]       shadow_arr [N_SIG];
   logic [E_W-1:0]         mac_term;
   logic                   cnt_clr;
   logic                   win_close;
   logic                   path_free;

   genvar gi;
   generate
      for (gi = 0; gi < N_SIG; gi++) begin : g_net
         toggle_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .sig     (sig_in[gi]),
            .cnt_en  (en),
            .clr     (cnt_clr),
            .cnt_sum (cnt_sum[gi*CNT_W +: CNT_W])
         );
         assign weight_arr[gi] = weights[gi*WEIGHT_W +: WEIGHT_W];
         assign shadow_arr[gi] = shadow_reg[gi*CNT_W +: CNT_W];
      end
   endgenerate

   // Counting in IDLE is harmless: the first enabled cycle is window cycle 0.
   always_comb begin
      win_close = (cnt_state_reg == ST_COUNT) && en && (win_cnt_reg == WIN_LAST);
      cnt_clr   = ((cnt_state_reg == ST_COUNT) && !en) || win_close;
      path_free = (rpt_state_reg == R_IDLE);
   end

   always_comb begin
      mac_term = '0;
      for (int i = 0; i < N_SIG; i++) begin
         if (mac_idx_reg == MI_W'(i))
            mac_term = E_W'(weight_arr[i]) * E_W'(shadow_arr[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_state_reg <= ST_IDLE;
         win_cnt_reg   <= '0;
      end else begin
         case (cnt_state_reg)
            ST_IDLE: begin
               if (en) begin
                  cnt_state_reg <= ST_COUNT;
                  win_cnt_reg   <= WC_W'(1);
               end
            end
            ST_COUNT: begin
               if (!en) begin
                  cnt_state_reg <= ST_IDLE;
                  win_cnt_reg   <= '0;
               end else if (win_cnt_reg == WIN_LAST) begin
                  win_cnt_reg <= '0;
               end else begin
                  win_cnt_reg <= win_cnt_reg + 1'b1;
               end
            end
            default: begin
               cnt_state_reg <= ST_IDLE;
               win_cnt_reg   <= '0;
            end
         endcase
      end
   end

   // Report path: one MAC step per net, one extra cycle to publish, then hold until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_state_reg <= R_IDLE;
         mac_idx_reg   <= '0;
         acc_reg       <= '0;
         shadow_reg    <= '0;
         rpt_valid     <= 1'b0;
         rpt_toggles   <= '0;
         rpt_energy    <= '0;
         drop_cnt      <= '0;
      end else begin
         if (win_close && !path_free && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;

         case (rpt_state_reg)
            R_IDLE: begin
               if (win_close) begin
                  shadow_reg    <= cnt_sum;
                  acc_reg       <= '0;
                  mac_idx_reg   <= '0;
                  rpt_state_reg <= R_MAC;
               end
            end
            R_MAC: begin
               if (mac_idx_reg == MI_W'(N_SIG)) begin
                  rpt_valid     <= 1'b1;
                  rpt_toggles   <= shadow_reg;
                  rpt_energy    <= acc_reg;
                  rpt_state_reg <= R_HOLD;
               end else begin
                  acc_reg     <= acc_reg + mac_term;
                  mac_idx_reg <= mac_idx_reg + 1'b1;
               end
            end
            R_HOLD: begin
               if (rpt_ready) begin
                  rpt_valid     <= 1'b0;
                  rpt_state_reg <= R_IDLE;
               end
            end
            default: begin
               rpt_valid     <= 1'b0;
               rpt_state_reg <= R_IDLE;
            end
         endcase
      end
   end

endmodule
